// File: rtl/morse_key_frontend.sv
// Morse key front end: synchronizes the raw key, optionally debounces it (MORSE_DEBOUNCE_EN),
// times presses and gaps, and emits dot/dash/end-of-character pulses on morse_signal.
module morse_key_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DOT_MAX         = 8,
    parameter int unsigned CHAR_GAP        = 16,
    parameter int unsigned MAX_SYMS        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic [1:0] morse_signal,
    output logic       key_level,
    output logic       busy
);

    localparam logic [15:0] DOT_MAX_C  = 16'(DOT_MAX);
    localparam logic [15:0] CHAR_GAP_C = 16'(CHAR_GAP);
    localparam logic [3:0]  MAX_SYMS_C = 4'(MAX_SYMS);

    localparam logic [1:0] SYM_IDLE = 2'b11;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_EOC  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRESS = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    logic        sync1_q;
    logic        sync2_q;
    logic        key_level_q;
    state_e      state_q;
    logic [15:0] pcnt_q;
    logic [15:0] gcnt_q;
    logic [3:0]  scnt_q;
    logic [1:0]  morse_q;

    // Two-flop synchronizer for the asynchronous key input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int unsigned      DCW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DCW-1:0]   DCNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    logic [DCW-1:0] dcnt_q;

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q      <= '0;
            key_level_q <= 1'b0;
        end else if (sync2_q != key_level_q) begin
            if (dcnt_q == DCNT_LAST) begin
                key_level_q <= sync2_q;
                dcnt_q      <= '0;
            end else begin
                dcnt_q <= dcnt_q + 1'b1;
            end
        end else begin
            dcnt_q <= '0;
        end
    end
`else
    // Without the filter the level is the synchronized key delayed one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level_q <= 1'b0;
        end else begin
            key_level_q <= sync2_q;
        end
    end
`endif

    // Press/gap timing FSM with registered symbol output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pcnt_q  <= 16'd0;
            gcnt_q  <= 16'd0;
            scnt_q  <= 4'd0;
            morse_q <= SYM_IDLE;
        end else begin
            morse_q <= SYM_IDLE;
            // A full character closes one cycle after its last symbol, whatever the state
            if (scnt_q == MAX_SYMS_C) begin
                morse_q <= SYM_EOC;
                scnt_q  <= 4'd0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (key_level_q) begin
                        state_q <= ST_PRESS;
                        pcnt_q  <= 16'd1;
                    end
                end
                ST_PRESS: begin
                    if (key_level_q) begin
                        if (pcnt_q != 16'hFFFF) begin
                            pcnt_q <= pcnt_q + 16'd1;
                        end
                    end else begin
                        morse_q <= (pcnt_q <= DOT_MAX_C) ? SYM_DOT : SYM_DASH;
                        scnt_q  <= scnt_q + 4'd1;
                        state_q <= ST_GAP;
                        gcnt_q  <= 16'd0;
                    end
                end
                ST_GAP: begin
                    if (key_level_q) begin
                        state_q <= ST_PRESS;
                        pcnt_q  <= 16'd1;
                        gcnt_q  <= 16'd0;
                    end else if (gcnt_q == CHAR_GAP_C) begin
                        if (scnt_q != 4'd0) begin
                            morse_q <= SYM_EOC;
                            scnt_q  <= 4'd0;
                        end
                        state_q <= ST_IDLE;
                    end else if (gcnt_q != 16'hFFFF) begin
                        gcnt_q <= gcnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign morse_signal = morse_q;
    assign key_level    = key_level_q;
    assign busy         = (scnt_q != 4'd0) || (state_q == ST_PRESS);

endmodule

// File: tb/tb_morse_key_frontend.sv
// Self-checking bench for morse_key_frontend: directed and random key waveforms are scored
// cycle by cycle against an event-level model (press/release runs, gaps, symbol counts).
module tb_morse_key_frontend;

    localparam int DEB  = 4;
    localparam int DOTM = 8;
    localparam int CG   = 16;
    localparam int MAXS = 6;
    localparam int MAXC = 6000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_in;
    logic [1:0] morse_signal;
    logic       key_level;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    bit         kin   [MAXC];
    bit         kl_m  [MAXC];
    logic [1:0] exp_m [MAXC];
    bit         exp_b [MAXC];
    int         n_cyc = 0;
    int         rises[$];
    int         falls[$];

    morse_key_frontend #(
        .DEBOUNCE_CYCLES(DEB),
        .DOT_MAX        (DOTM),
        .CHAR_GAP       (CG),
        .MAX_SYMS       (MAXS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .morse_signal(morse_signal),
        .key_level   (key_level),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_seg(input bit lvl, input int len);
        for (int i = 0; i < len; i++) begin
            if (n_cyc < MAXC) begin
                kin[n_cyc] = lvl;
                n_cyc++;
            end
        end
    endtask

    // Synchronized key as seen at clock edge e (two edges of pipeline)
    function automatic bit s_at(input int e);
        if (e >= 2) return kin[e-2];
        else return 1'b0;
    endfunction

    task automatic set_m(input int idx, input logic [1:0] v);
        if (idx >= 0 && idx < n_cyc) exp_m[idx] = v;
    endtask

    task automatic set_b(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            if (i >= 0 && i < n_cyc) exp_b[i] = 1'b1;
        end
    endtask

    task automatic build_model();
        bit cur;
        bit all_diff;
        bit prev;
        int r, f, p, n, rn, cnt;
        cur = 1'b0;
        for (int e = 0; e < n_cyc; e++) begin
`ifdef MORSE_DEBOUNCE_EN
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++) begin
                if (s_at(e - k) == cur) all_diff = 1'b0;
            end
            if (all_diff) cur = ~cur;
            kl_m[e] = cur;
`else
            all_diff = 1'b0;
            kl_m[e] = s_at(e);
`endif
        end
        prev = 1'b0;
        for (int e = 0; e < n_cyc; e++) begin
            if (kl_m[e] && !prev) rises.push_back(e);
            if (!kl_m[e] && prev) falls.push_back(e);
            prev = kl_m[e];
            exp_m[e] = 2'b11;
            exp_b[e] = 1'b0;
        end
        cnt = 0;
        for (int i = 0; i < rises.size(); i++) begin
            r = rises[i];
            f = (i < falls.size()) ? falls[i] : n_cyc;
            set_b(r + 1, f);
            if (f >= n_cyc) break;
            p = f + 1;
            n = f - r;
            set_m(p, (n <= DOTM) ? 2'b01 : 2'b10);
            cnt++;
            rn = (i + 1 < rises.size()) ? rises[i+1] : n_cyc + CG + 10;
            if (cnt == MAXS) begin
                set_m(p + 1, 2'b00);
                set_b(p, p);
                cnt = 0;
            end else if (rn - f >= CG + 2) begin
                set_m(f + CG + 2, 2'b00);
                set_b(p, f + CG + 1);
                cnt = 0;
            end else begin
                set_b(p, rn);
            end
        end
    endtask

    initial begin
        int hi, lo;
        rst_n  = 1'b0;
        key_in = 1'b0;

        add_seg(1'b0, 10);
        add_seg(1'b1, 5);  add_seg(1'b0, 30);
        add_seg(1'b1, 8);  add_seg(1'b0, 3);
        add_seg(1'b1, 9);  add_seg(1'b0, 30);
        for (int g = 0; g < 3; g++) begin
            add_seg(1'b1, 2); add_seg(1'b0, 10);
        end
        add_seg(1'b0, 30);
        for (int d = 0; d < 7; d++) begin
            add_seg(1'b1, 5); add_seg(1'b0, 4);
        end
        add_seg(1'b0, 30);
        add_seg(1'b1, 5);  add_seg(1'b0, 4);
        add_seg(1'b1, 12); add_seg(1'b0, 30);
        for (int j = 0; j < 60; j++) begin
            hi = $urandom_range(22, 1);
            lo = ($urandom_range(3, 0) == 0) ? $urandom_range(40, 17) : $urandom_range(12, 1);
            add_seg(1'b1, hi);
            add_seg(1'b0, lo);
        end
        add_seg(1'b0, 40);
        build_model();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_morse", 16'(morse_signal), 16'h0003);
        check_val("reset_level", 16'(key_level), 16'h0000);
        check_val("reset_busy", 16'(busy), 16'h0000);
        rst_n = 1'b1;

        for (int c = 0; c < n_cyc; c++) begin
            key_in = kin[c];
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("morse@%0d", c), 16'(morse_signal), 16'(exp_m[c]));
            check_val($sformatf("level@%0d", c), 16'(key_level), 16'(kl_m[c]));
            check_val($sformatf("busy@%0d", c), 16'(busy), 16'(exp_b[c]));
        end

        // Reset in the middle of a long press
        key_in = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_val("press_busy", 16'(busy), 16'h0001);
        check_val("press_level", 16'(key_level), 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_morse", 16'(morse_signal), 16'h0003);
        check_val("midrst_level", 16'(key_level), 16'h0000);
        check_val("midrst_busy", 16'(busy), 16'h0000);
        repeat (8) @(posedge clk);
        @(negedge clk);
        key_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("postrst_morse@%0d", c), 16'(morse_signal), 16'h0003);
            check_val($sformatf("postrst_busy@%0d", c), 16'(busy), 16'h0000);
            check_val($sformatf("postrst_level@%0d", c), 16'(key_level), 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/morse_key_frontend.md
# morse_key_frontend

Converts a raw, bouncy Morse key input into the 2-bit symbol stream consumed by the Morse character decoder. The block synchronizes and debounces the key, measures press and release durations, and classifies each press as dot or dash. It emits an end-of-character marker after a sufficient release gap. It sits directly upstream of the decoder and drives its `morse_signal` input.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized cycles required to accept a key level change (≥1).
- `DOT_MAX`, 8: press length in cycles ≤ DOT_MAX is a dot; > DOT_MAX is a dash.
- `CHAR_GAP`, 16: released cycles after the last symbol before end-of-character is emitted (≥1).
- `MAX_SYMS`, 6: symbols per character before end-of-character is forced (1..15).
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `key_in` input 1: raw key, active-high, asynchronous to `clk`.
- `morse_signal` output 2: 2'b11 idle; 2'b01 dot; 2'b10 dash; 2'b00 end-of-character. Each non-idle code is a one-cycle pulse.
- `key_level` output 1: debounced key level.
- `busy` output 1: high while a character is in progress (symbol count > 0 or state PRESS).

## Operation
- **Reset values:** `morse_signal`=2'b11, `key_level`=0, `busy`=0. Synchronizer flops, all counters, and the symbol count clear to 0. The FSM resets to IDLE.
- **Synchronizer:** two flops on `key_in`; the second flop's output is `s`.
- **Debounce:** `dcnt` increments each cycle `s`≠`key_level` and clears to 0 when they are equal. When `dcnt`==DEBOUNCE_CYCLES-1 and `s`≠`key_level`, `key_level`<=`s` and `dcnt`<=0.
- **FSM states:** IDLE, PRESS, GAP.
  - IDLE: waits for `key_level` to go 1. On the rise: go to PRESS, `pcnt`<=1.
  - PRESS: `pcnt` increments each cycle `key_level`=1, 16 bits, saturating at 16'hFFFF. On the fall, in the cycle after `key_level` goes 0:
    - emit 2'b01 if `pcnt`≤DOT_MAX, else 2'b10;
    - increment `scnt`;
    - go to GAP with `gcnt`<=0.
  - GAP: `gcnt` increments each cycle `key_level`=0, 16 bits, saturating.
    - When `gcnt` reaches CHAR_GAP and `scnt`>0: emit 2'b00, `scnt`<=0, go to IDLE.
    - If `scnt`==0 at that point (already forced): go to IDLE with no emission.
    - `key_level` rising in GAP: go to PRESS, `pcnt`<=1, `gcnt` cleared, no end marker.
- **Forced end:** on the cycle after the symbol that makes `scnt`==MAX_SYMS, emit 2'b00 and set `scnt`<=0. The FSM stays in its current state.
- **Pulse ordering:** at most one non-idle code per cycle. A forced 2'b00 never coincides with a dot or dash, because a symbol requires a new press of at least DEBOUNCE_CYCLES cycles.
- **Mid-operation reset:** the reset assertion clears everything immediately. No partial symbol or end marker is emitted after release.

## Timing
- **`key_in` to `key_level` latency:** 2 + DEBOUNCE_CYCLES edges for a clean step.
- **Release to symbol:**
  - Symbol pulse appears 1 cycle after `key_level` falls.
  - `pcnt` counts cycles where `key_level`=1, inclusive of the rise cycle.
- **End marker:** appears CHAR_GAP+1 cycles after the dot or dash pulse, provided no new press occurs.
- **Glitches:** a `key_in` glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes `key_level` or `morse_signal`.
- **Long press:** a press held ≥65535 cycles is still a single dash.

## Configuration
- **`MORSE_DEBOUNCE_EN` defined:** debounce filter as above.
- **`MORSE_DEBOUNCE_EN` undefined:**
  - `key_level` = `s` registered one cycle; DEBOUNCE_CYCLES is ignored and `dcnt` is absent.
  - Latency from `key_in` to `key_level` is 3 edges.
  - Glitches of one or more cycles produce symbols.

## Test plan
Defaults are used unless stated: DEBOUNCE 4, DOT_MAX 8, CHAR_GAP 16, MAX_SYMS 6.
- **Dot then end:** press 5 cycles, release 30 → one 2'b01 pulse, then 2'b00 exactly 17 cycles later; `morse_signal` 2'b11 otherwise.
- **Dot/dash boundary:** press 8 cycles → 2'b01; press 9 cycles → 2'b10; release 3 cycles between presses (< gap) → no 2'b00 between them.
- **Bounce:** 2-cycle high glitches on `key_in` → `key_level` stays 0 and no pulses. Without `MORSE_DEBOUNCE_EN`, the same stimulus yields 2'b01 per glitch.
- **Forced end:** seven dots with 4-cycle gaps → six 2'b01 pulses, then 2'b00 one cycle after the 6th; the 7th dot starts a new character, which ends with 2'b00 after the gap.
- **Reset mid-press:** assert `rst_n`=0 during a 20-cycle press, then release → all outputs at reset values, no dash or 2'b00 emitted, and `busy`=0.
- **End-to-end with decoder:** key ".-" (5 high, 4 low, 12 high, 30 low) → decoder `decoded_char` = "A".
